// File: rtl/beta_pkg.sv
// Shared encodings for the Beta execute/memory slice: opcodes, functs,
// ALU operations and the packed control bundle produced by the decoder.
package beta_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_AND  = 5'b00010,
      ALU_OR   = 5'b00011,
      ALU_XOR  = 5'b00100,
      ALU_NOR  = 5'b00101,
      ALU_SLT  = 5'b00110,
      ALU_SLTU = 5'b00111,
      ALU_SLL  = 5'b01000,
      ALU_SRL  = 5'b01001,
      ALU_SRA  = 5'b01010
   } aluop_e;

   typedef enum logic [1:0] {
      RD_RD  = 2'b00,
      RD_RT  = 2'b01,
      RD_EXC = 2'b10,
      RD_RA  = 2'b11
   } reg_dst_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_ABS  = 2'b01,
      JMP_REG  = 2'b10
   } jump_e;

   typedef enum logic [1:0] {
      OP2_B     = 2'b00,
      OP2_SEXT  = 2'b01,
      OP2_ZEXT  = 2'b10,
      OP2_SHAMT = 2'b11
   } op2_sel_e;

   typedef struct packed {
      reg_dst_e reg_dst;
      logic     reg_write;
      logic     mem_write;
      logic     mem_read;
      logic     mem_to_reg;
      logic     branch;
      logic     branch_ne;
      jump_e    jump;
      logic     ill_op;
   } ctrl_t;

endpackage

// File: rtl/beta_alu.sv
// 32-bit combinational ALU with zero, signed-overflow and negative flags.
module beta_alu
   import beta_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] op2_i,
   input  aluop_e          aluop_i,
   output logic [XLEN-1:0] y_o,
   output logic            z_o,
   output logic            v_o,
   output logic            n_o
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [4:0]      shamt;

   assign sum   = a_i + op2_i;
   assign diff  = a_i - op2_i;
   assign shamt = op2_i[4:0];

   always_comb begin
      y_o = '0;
      v_o = 1'b0;
      case (aluop_i)
         ALU_ADD: begin
            y_o = sum;
            v_o = (a_i[XLEN-1] == op2_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_SUB: begin
            y_o = diff;
            v_o = (a_i[XLEN-1] != op2_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_AND:  y_o = a_i & op2_i;
         ALU_OR:   y_o = a_i | op2_i;
         ALU_XOR:  y_o = a_i ^ op2_i;
         ALU_NOR:  y_o = ~(a_i | op2_i);
         ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(op2_i));
         ALU_SLTU: y_o = XLEN'(a_i < op2_i);
         ALU_SLL:  y_o = a_i << shamt;
         ALU_SRL:  y_o = a_i >> shamt;
         ALU_SRA:  y_o = XLEN'($signed(a_i) >>> shamt);
         default:  y_o = '0;
      endcase
   end

   assign z_o = (y_o == '0);
   assign n_o = y_o[XLEN-1];

endmodule

// File: rtl/beta_exec_slice.sv
// Beta execute/memory slice: instruction decode, operand-2 select, ALU and
// word-addressed data memory with combinational read and clocked write.
module beta_exec_slice
   import beta_pkg::*;
#(
   parameter int unsigned DMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            irq,
   input  logic            supervisor,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [1:0]      reg_dst,
   output logic            reg_write,
   output logic            mem_write,
   output logic            mem_read,
   output logic            mem_to_reg,
   output logic            branch,
   output logic            branch_ne,
   output logic [1:0]      jump,
   output logic            ill_op,
   output logic [XLEN-1:0] alu_y,
   output logic            z,
   output logic            v,
   output logic            n,
   output logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] wb_data
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   ctrl_t       ctrl;
   aluop_e      aluop;
   op2_sel_e    op2_sel;
   logic        illegal;
   logic [XLEN-1:0] op2;
   logic [AW-1:0]   mem_idx;
   logic [XLEN-1:0] mem [DMEM_WORDS];
   logic            unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign imm           = instr[15:0];
   assign unused_fields = ^instr[25:16];

   // Decode, then let exceptions and reset override in priority order.
   always_comb begin
      ctrl    = '0;
      aluop   = ALU_ADD;
      op2_sel = OP2_B;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  aluop = ALU_ADD;
               FN_SUB:  aluop = ALU_SUB;
               FN_AND:  aluop = ALU_AND;
               FN_OR:   aluop = ALU_OR;
               FN_XOR:  aluop = ALU_XOR;
               FN_NOR:  aluop = ALU_NOR;
               FN_SLT:  aluop = ALU_SLT;
               FN_SLTU: aluop = ALU_SLTU;
               FN_SLL:  begin aluop = ALU_SLL; op2_sel = OP2_SHAMT; end
               FN_SRL:  begin aluop = ALU_SRL; op2_sel = OP2_SHAMT; end
               FN_SRA:  begin aluop = ALU_SRA; op2_sel = OP2_SHAMT; end
               FN_JR:   begin ctrl.reg_write = 1'b0; ctrl.jump = JMP_REG; end
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin ctrl.reg_dst = RD_RT; ctrl.reg_write = 1'b1; op2_sel = OP2_SEXT; end
         OP_ANDI: begin ctrl.reg_dst = RD_RT; ctrl.reg_write = 1'b1; aluop = ALU_AND; op2_sel = OP2_ZEXT; end
         OP_ORI:  begin ctrl.reg_dst = RD_RT; ctrl.reg_write = 1'b1; aluop = ALU_OR;  op2_sel = OP2_ZEXT; end
         OP_XORI: begin ctrl.reg_dst = RD_RT; ctrl.reg_write = 1'b1; aluop = ALU_XOR; op2_sel = OP2_ZEXT; end
         OP_LW: begin
            ctrl.reg_dst    = RD_RT;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            op2_sel         = OP2_SEXT;
         end
         OP_SW:  begin ctrl.mem_write = 1'b1; op2_sel = OP2_SEXT; end
         OP_BEQ: begin ctrl.branch = 1'b1; aluop = ALU_SUB; end
         OP_BNE: begin ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; aluop = ALU_SUB; end
         OP_J:   ctrl.jump = JMP_ABS;
         OP_JAL: begin ctrl.jump = JMP_ABS; ctrl.reg_write = 1'b1; ctrl.reg_dst = RD_RA; end
         default: illegal = 1'b1;
      endcase

      if (illegal || (irq && !supervisor)) begin
         ctrl           = '0;
         ctrl.reg_dst   = RD_EXC;
         ctrl.reg_write = 1'b1;
         ctrl.ill_op    = illegal;
         aluop          = ALU_ADD;
         op2_sel        = OP2_B;
      end

      if (!reset) begin
         ctrl    = '0;
         aluop   = ALU_ADD;
         op2_sel = OP2_B;
      end
   end

   always_comb begin
      case (op2_sel)
         OP2_SEXT:  op2 = {{16{imm[15]}}, imm};
         OP2_ZEXT:  op2 = XLEN'(imm);
         OP2_SHAMT: op2 = XLEN'(instr[10:6]);
         default:   op2 = b;
      endcase
   end

   beta_alu u_alu (
      .a_i     (a),
      .op2_i   (op2),
      .aluop_i (aluop),
      .y_o     (alu_y),
      .z_o     (z),
      .v_o     (v),
      .n_o     (n)
   );

   // Word index; byte offset and bits above the array depth are dropped.
   assign mem_idx = alu_y[AW+1:2];

   always_ff @(posedge clk) begin
      if (ctrl.mem_write) begin
         mem[mem_idx] <= b;
      end
   end

   assign mem_rdata = ctrl.mem_read ? mem[mem_idx] : '0;
   assign wb_data   = ctrl.mem_to_reg ? mem_rdata : alu_y;

   assign reg_dst    = ctrl.reg_dst;
   assign reg_write  = ctrl.reg_write;
   assign mem_write  = ctrl.mem_write;
   assign mem_read   = ctrl.mem_read;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign branch     = ctrl.branch;
   assign branch_ne  = ctrl.branch_ne;
   assign jump       = ctrl.jump;
   assign ill_op     = ctrl.ill_op;

endmodule

// File: tb/tb_beta_exec_slice.sv
// Scoreboard bench for beta_exec_slice: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the combinational outputs.
module tb_beta_exec_slice;

   logic        clk = 1'b0;
   logic        reset, irq, supervisor;
   logic [31:0] instr, a, b;
   logic [1:0]  reg_dst, jump;
   logic        reg_write, mem_write, mem_read, mem_to_reg, branch, branch_ne, ill_op;
   logic [31:0] alu_y, mem_rdata, wb_data;
   logic        z, v, n;

   int checks = 0;
   int errors = 0;

   // ctrl = {reg_dst, reg_write, mem_write, mem_read, mem_to_reg, branch, branch_ne, jump, ill_op}
   localparam logic [10:0] C_NONE = 11'b00_0_0_0_0_0_0_00_0;
   localparam logic [10:0] C_R    = 11'b00_1_0_0_0_0_0_00_0;
   localparam logic [10:0] C_I    = 11'b01_1_0_0_0_0_0_00_0;
   localparam logic [10:0] C_LW   = 11'b01_1_0_1_1_0_0_00_0;
   localparam logic [10:0] C_SW   = 11'b00_0_1_0_0_0_0_00_0;
   localparam logic [10:0] C_BEQ  = 11'b00_0_0_0_0_1_0_00_0;
   localparam logic [10:0] C_BNE  = 11'b00_0_0_0_0_1_1_00_0;
   localparam logic [10:0] C_JAL  = 11'b11_1_0_0_0_0_0_01_0;
   localparam logic [10:0] C_JR   = 11'b00_0_0_0_0_0_0_10_0;
   localparam logic [10:0] C_EXC  = 11'b10_1_0_0_0_0_0_00_0;
   localparam logic [10:0] C_ILL  = 11'b10_1_0_0_0_0_0_00_1;

   typedef struct {
      string       name;
      logic [10:0] ctrl;
      logic [31:0] y;
      logic [2:0]  zvn;
      logic [31:0] rdata;
      logic [31:0] wb;
   } exp_t;

   exp_t exp_q[$];

   beta_exec_slice dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .supervisor (supervisor),
      .instr      (instr),
      .a          (a),
      .b          (b),
      .reg_dst    (reg_dst),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_to_reg (mem_to_reg),
      .branch     (branch),
      .branch_ne  (branch_ne),
      .jump       (jump),
      .ill_op     (ill_op),
      .alu_y      (alu_y),
      .z          (z),
      .v          (v),
      .n          (n),
      .mem_rdata  (mem_rdata),
      .wb_data    (wb_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
      return {6'b000000, 5'd1, 5'd2, 5'd3, sh, fn};
   endfunction

   function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] im);
      return {op, 5'd1, 5'd2, im};
   endfunction

   task automatic issue(input string nm, input logic rs, input logic iq, input logic sv,
                        input logic [31:0] in, input logic [31:0] av, input logic [31:0] bv,
                        input logic [10:0] c, input logic [31:0] y, input logic [2:0] f,
                        input logic [31:0] rd, input logic [31:0] wb);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rs; irq = iq; supervisor = sv; instr = in; a = av; b = bv;
      e.name = nm; e.ctrl = c; e.y = y; e.zvn = f; e.rdata = rd; e.wb = wb;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got %h exp %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are settled mid-cycle, before the next write edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp(e.name, "ctrl", 32'({reg_dst, reg_write, mem_write, mem_read, mem_to_reg,
                                  branch, branch_ne, jump, ill_op}), 32'(e.ctrl));
         cmp(e.name, "y", alu_y, e.y);
         cmp(e.name, "zvn", 32'({z, v, n}), 32'(e.zvn));
         cmp(e.name, "rdata", mem_rdata, e.rdata);
         cmp(e.name, "wb", wb_data, e.wb);
      end
   end

   initial begin
      reset = 1'b0; irq = 1'b0; supervisor = 1'b0; instr = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);

      issue("rst_idle", 0, 0, 0, rt(6'h20, 0), 32'h3, 32'h4, C_NONE, 32'h7, 3'b000, 0, 32'h7);
      issue("sw_seed", 1, 0, 0, it(6'h2B, 16'h0), 32'h10, 32'h12345678, C_SW, 32'h10, 3'b000, 0, 32'h10);
      issue("rst_sw", 0, 0, 0, it(6'h2B, 16'h0), 32'h10, 32'h55, C_NONE, 32'h65, 3'b000, 0, 32'h65);
      issue("lw_after_rst", 1, 0, 0, it(6'h23, 16'h0), 32'h10, 32'h0, C_LW, 32'h10, 3'b000, 32'h12345678, 32'h12345678);

      issue("add_ovf", 1, 0, 0, rt(6'h20, 0), 32'h7FFFFFFF, 32'h1, C_R, 32'h80000000, 3'b011, 0, 32'h80000000);
      issue("sub_zero", 1, 0, 0, rt(6'h22, 0), 32'h5, 32'h5, C_R, 32'h0, 3'b100, 0, 32'h0);
      issue("sub_ovf", 1, 0, 0, rt(6'h22, 0), 32'h80000000, 32'h1, C_R, 32'h7FFFFFFF, 3'b010, 0, 32'h7FFFFFFF);
      issue("slt", 1, 0, 0, rt(6'h2A, 0), 32'hFFFFFFFF, 32'h1, C_R, 32'h1, 3'b000, 0, 32'h1);
      issue("sltu", 1, 0, 0, rt(6'h2B, 0), 32'hFFFFFFFF, 32'h1, C_R, 32'h0, 3'b100, 0, 32'h0);
      issue("and", 1, 0, 0, rt(6'h24, 0), 32'h0000F0F0, 32'h0000FF00, C_R, 32'h0000F000, 3'b000, 0, 32'h0000F000);
      issue("nor", 1, 0, 0, rt(6'h27, 0), 32'h0, 32'h0, C_R, 32'hFFFFFFFF, 3'b001, 0, 32'hFFFFFFFF);

      issue("addi_neg", 1, 0, 0, it(6'h08, 16'hFFFC), 32'h8, 32'h0, C_I, 32'h4, 3'b000, 0, 32'h4);
      issue("ori_zext", 1, 0, 0, it(6'h0D, 16'h8000), 32'h0, 32'h0, C_I, 32'h00008000, 3'b000, 0, 32'h00008000);
      issue("sll", 1, 0, 0, rt(6'h00, 5'd4), 32'h1, 32'hFFFFFFFF, C_R, 32'h10, 3'b000, 0, 32'h10);
      issue("sra", 1, 0, 0, rt(6'h03, 5'd4), 32'h80000000, 32'h0, C_R, 32'hF8000000, 3'b001, 0, 32'hF8000000);
      issue("srl31", 1, 0, 0, rt(6'h02, 5'd31), 32'h80000000, 32'h0, C_R, 32'h1, 3'b000, 0, 32'h1);

      issue("sw_beef", 1, 0, 0, it(6'h2B, 16'h4), 32'h100, 32'hDEADBEEF, C_SW, 32'h104, 3'b000, 0, 32'h104);
      issue("lw_beef", 1, 0, 0, it(6'h23, 16'h0), 32'h104, 32'h0, C_LW, 32'h104, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF);
      issue("lw_alias", 1, 0, 0, it(6'h23, 16'h0), 32'h504, 32'h0, C_LW, 32'h504, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF);

      issue("beq", 1, 0, 0, it(6'h04, 16'h10), 32'h7, 32'h7, C_BEQ, 32'h0, 3'b100, 0, 32'h0);
      issue("bne", 1, 0, 0, it(6'h05, 16'h10), 32'h7, 32'h3, C_BNE, 32'h4, 3'b000, 0, 32'h4);
      issue("jal", 1, 0, 0, {6'h03, 26'h0000123}, 32'h0, 32'h0, C_JAL, 32'h0, 3'b100, 0, 32'h0);
      issue("jr", 1, 0, 0, rt(6'h08, 0), 32'h40, 32'h0, C_JR, 32'h40, 3'b000, 0, 32'h40);

      issue("ill_op", 1, 0, 0, it(6'h3F, 16'h0), 32'h1, 32'h2, C_ILL, 32'h3, 3'b000, 0, 32'h3);
      issue("ill_funct", 1, 0, 0, rt(6'h3F, 0), 32'h1, 32'h2, C_ILL, 32'h3, 3'b000, 0, 32'h3);
      issue("irq_user", 1, 1, 0, rt(6'h22, 0), 32'h1, 32'h2, C_EXC, 32'h3, 3'b000, 0, 32'h3);
      issue("irq_kernel", 1, 1, 1, rt(6'h20, 0), 32'h1, 32'h2, C_R, 32'h3, 3'b000, 0, 32'h3);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
